// File: rtl/sd_cmd_spi.sv
// SD command engine in SPI mode 0: sends a 48-bit command frame and collects R1 / R3 / R7 responses.
// Define SD_CRC7_EN to compute CRC7 in hardware; otherwise fixed CRC bytes are used.
module sd_cmd_spi #(
  parameter int unsigned CLK_DIV      = 25,
  parameter int unsigned RESP_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        resp_ext,
  output logic        cmd_busy,
  output logic        cmd_done,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_data,
  output logic        resp_timeout,
  output logic        SD_CK,
  output logic        SD_MOSI,
  input  logic        SD_MISO
);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT, R1, EXT, TAIL, DONE
  } state_t;

  localparam logic [8:0]  HALF    = 9'(CLK_DIV);
  localparam logic [8:0]  LAST    = 9'(2 * CLK_DIV - 1);
  localparam logic [15:0] TO_LAST = 16'(8 * RESP_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [8:0]  div_q;
  logic [15:0] bit_q;
  logic [47:0] frame_q;
  logic [31:0] rx_q;
  logic        ext_q;
  logic [6:0]  crc7;
  logic        active, rise, bit_end, accept;

`ifdef SD_CRC7_EN
  function automatic logic [6:0] crc7_f(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign crc7 = crc7_f({2'b01, cmd_index, cmd_arg});
`else
  always_comb begin
    crc7 = 7'h7F;
    unique case (1'b1)
      (cmd_index == 6'd0): crc7 = 7'h4A;
      (cmd_index == 6'd8): crc7 = 7'h43;
      default: crc7 = 7'h7F;
    endcase
  end
`endif

  assign active  = (state_q != IDLE) && (state_q != DONE);
  assign rise    = active && (div_q == HALF);
  assign bit_end = active && (div_q == LAST);
  assign accept  = (state_q == IDLE) && cmd_start;

  assign cmd_busy = (state_q != IDLE);
  assign cmd_done = (state_q == DONE);
  assign SD_CK    = active && (div_q >= HALF);
  assign SD_MOSI  = (state_q == SEND) ? frame_q[47] : 1'b1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_start) state_d = SEND;
      SEND: if (bit_end && bit_q == 16'd47) state_d = WAIT;
      WAIT: begin
        // a zero at the last timeout bit still counts as a start bit
        if (bit_end) begin
          if (!rx_q[0])              state_d = R1;
          else if (bit_q == TO_LAST) state_d = TAIL;
        end
      end
      R1:   if (bit_end && bit_q == 16'd6) state_d = ext_q ? EXT : TAIL;
      EXT:  if (bit_end && bit_q == 16'd31) state_d = TAIL;
      TAIL: if (bit_end && bit_q == 16'd7) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      frame_q      <= '1;
      rx_q         <= '0;
      ext_q        <= 1'b0;
      resp_r1      <= 8'hFF;
      resp_data    <= '0;
      resp_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        frame_q      <= {2'b01, cmd_index, cmd_arg, crc7, 1'b1};
        ext_q        <= resp_ext;
        resp_timeout <= 1'b0;
        div_q        <= '0;
        bit_q        <= '0;
      end else if (active) begin
        div_q <= bit_end ? 9'd0 : div_q + 9'd1;
        if (rise) rx_q <= {rx_q[30:0], SD_MISO};
        if (bit_end) begin
          bit_q <= (state_d != state_q) ? 16'd0 : bit_q + 16'd1;
          if (state_q == SEND) frame_q <= {frame_q[46:0], 1'b1};
          if (state_q == WAIT && state_d == TAIL) begin
            resp_r1      <= 8'hFF;
            resp_timeout <= 1'b1;
          end
          if (state_q == R1 && state_d != R1) resp_r1 <= rx_q[7:0];
          if (state_q == EXT && state_d != EXT) resp_data <= rx_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_spi.sv
// Directed bench for sd_cmd_spi: card model on SD_MISO, expected results queued per command.
// Build with or without SD_CRC7_EN; only the CMD55 CRC byte differs.
module tb_sd_cmd_spi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_ext;
  logic        cmd_busy;
  logic        cmd_done;
  logic [7:0]  resp_r1;
  logic [31:0] resp_data;
  logic        resp_timeout;
  logic        SD_CK;
  logic        SD_MOSI;
  logic        SD_MISO;

  typedef struct {
    logic [47:0] frame;
    logic [7:0]  r1;
    logic [31:0] data;
    logic        to;
    int          bits;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdata  = '0;

  always #5 clk = ~clk;

  sd_cmd_spi #(.CLK_DIV(3), .RESP_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .resp_ext(resp_ext),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done),
    .resp_r1(resp_r1), .resp_data(resp_data),
    .resp_timeout(resp_timeout),
    .SD_CK(SD_CK), .SD_MOSI(SD_MOSI), .SD_MISO(SD_MISO)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic miso_bit(input int p, input int dly,
                                    input logic ext, input logic [39:0] r,
                                    input logic to);
    int q, nb;
    q  = p - 48 - dly;
    nb = ext ? 40 : 8;
    if (to || q < 0 || q >= nb) return 1'b1;
    return r[39-q];
  endfunction

  task automatic xfer(input logic [5:0] idx, input logic [31:0] arg,
                      input logic [7:0] last, input logic ext,
                      input int dly, input logic [39:0] resp,
                      input logic to, input logic poke);
    exp_t        e, g;
    int          rises, dones;
    logic [47:0] fr;
    logic        prev, seen, clr;
    e.frame = {2'b01, idx, arg, last};
    e.to    = to;
    e.r1    = to ? 8'hFF : resp[39:32];
    if (ext && !to) mdata = resp[31:0];
    e.data  = mdata;
    e.bits  = to ? 120 : 64 + dly + (ext ? 32 : 0);
    sb.push_back(e);
    cmd_index = idx;
    cmd_arg   = arg;
    resp_ext  = ext;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("busy_accept", 64'(cmd_busy), 64'd1);
    chk("to_clear", 64'(resp_timeout), 64'd0);
    rises   = 0;
    fr      = '0;
    prev    = SD_CK;
    seen    = 1'b0;
    clr     = 1'b0;
    SD_MISO = 1'b1;
    for (int n = 0; n < 20000 && !seen; n++) begin
      @(negedge clk);
      if (clr) begin
        cmd_start = 1'b0;
        clr       = 1'b0;
      end
      if (SD_CK && !prev) begin
        if (rises < 48) fr = {fr[46:0], SD_MOSI};
        rises++;
        if (poke && rises == 10) begin
          cmd_index = ~idx;
          cmd_arg   = ~arg;
          cmd_start = 1'b1;
          clr       = 1'b1;
        end
      end
      if (!SD_CK && prev) SD_MISO = miso_bit(rises, dly, ext, resp, to);
      prev = SD_CK;
      if (cmd_done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (sb.size() > 0) begin
      g = sb.pop_front();
      chk("frame", 64'(fr), 64'(g.frame));
      chk("resp_r1", 64'(resp_r1), 64'(g.r1));
      chk("resp_data", 64'(resp_data), 64'(g.data));
      chk("resp_timeout", 64'(resp_timeout), 64'(g.to));
      chk("bit_periods", 64'(rises), 64'(g.bits));
    end
    chk("busy_at_done", 64'(cmd_busy), 64'd1);
    dones = seen ? 1 : 0;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("busy_after_done", 64'(cmd_busy), 64'd0);
    if (cmd_done) dones++;
    repeat (4) begin
      @(negedge clk);
      if (cmd_done) dones++;
    end
    chk("done_once", 64'(dones), 64'd1);
  endtask

  initial begin
    int   r, dn;
    logic prev;
    rst_n     = 1'b0;
    cmd_start = 1'b0;
    cmd_index = '0;
    cmd_arg   = '0;
    resp_ext  = 1'b0;
    SD_MISO   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ck", 64'(SD_CK), 64'd0);
    chk("rst_mosi", 64'(SD_MOSI), 64'd1);
    chk("rst_busy", 64'(cmd_busy), 64'd0);
    chk("rst_done", 64'(cmd_done), 64'd0);
    chk("rst_r1", 64'(resp_r1), 64'hFF);
    chk("rst_data", 64'(resp_data), 64'd0);
    chk("rst_to", 64'(resp_timeout), 64'd0);
    @(negedge clk);

    xfer(6'd0, 32'h0, 8'h95, 1'b0, 1, {8'h01, 32'h0}, 1'b0, 1'b0);
    xfer(6'd8, 32'h1AA, 8'h87, 1'b1, 0, {8'h01, 32'h000001AA}, 1'b0, 1'b0);
    xfer(6'd0, 32'h0, 8'h95, 1'b0, 0, 40'hFF_FFFF_FFFF, 1'b1, 1'b0);
`ifdef SD_CRC7_EN
    xfer(6'd55, 32'h0, 8'h65, 1'b0, 3, {8'h00, 32'h0}, 1'b0, 1'b0);
`else
    xfer(6'd55, 32'h0, 8'hFF, 1'b0, 3, {8'h00, 32'h0}, 1'b0, 1'b0);
`endif
    xfer(6'd8, 32'h1AA, 8'h87, 1'b0, 2, {8'h05, 32'h0}, 1'b0, 1'b1);

    cmd_index = 6'd0;
    cmd_arg   = 32'h0;
    resp_ext  = 1'b0;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    r    = 0;
    prev = SD_CK;
    for (int n = 0; n < 2000 && r < 21; n++) begin
      @(negedge clk);
      if (SD_CK && !prev) r++;
      prev = SD_CK;
    end
    chk("abort_reached", 64'(r), 64'd21);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ck", 64'(SD_CK), 64'd0);
    chk("abort_mosi", 64'(SD_MOSI), 64'd1);
    chk("abort_busy", 64'(cmd_busy), 64'd0);
    chk("abort_done", 64'(cmd_done), 64'd0);
    chk("abort_r1", 64'(resp_r1), 64'hFF);
    chk("abort_data", 64'(resp_data), 64'd0);
    rst_n = 1'b1;
    mdata = '0;
    dn    = 0;
    repeat (300) begin
      @(negedge clk);
      if (cmd_done) dn++;
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    chk("abort_idle", 64'(cmd_busy), 64'd0);
    xfer(6'd0, 32'h0, 8'h95, 1'b0, 1, {8'h01, 32'h0}, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_cmd_spi.md
SD_CMD_SPI -- requirements
Module: sd_cmd_spi

Interface
REQ-001 Parameter CLK_DIV, default 25, sets half-period of SD_CK in clk cycles (SD_CK = clk/(2*CLK_DIV)); legal range 1..255.
REQ-002 Parameter RESP_TIMEOUT, default 8, sets max response wait (Ncr) in bytes.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cmd_start  input  1  one-cycle request; accepted only when cmd_busy=0.
REQ-006 cmd_index  input  6  SD command index; sampled with cmd_start.
REQ-007 cmd_arg  input  32  command argument; sampled with cmd_start.
REQ-008 resp_ext  input  1  1 = R3/R7 response (R1 + 32 bits); sampled with cmd_start.
REQ-009 cmd_busy  output  1  high from cycle after acceptance through cmd_done cycle.
REQ-010 cmd_done  output  1  one-cycle pulse at end of transaction.
REQ-011 resp_r1  output  8  received R1 byte; 0xFF on timeout.
REQ-012 resp_data  output  32  extra response bits, MSB first; valid with cmd_done when resp_ext=1.
REQ-013 resp_timeout  output  1  set with cmd_done when no R1 start bit seen; held until next acceptance.
REQ-014 SD_CK  output  1  SPI clock to card, idle low (mode 0).
REQ-015 SD_MOSI  output  1  serial data to card, idle high.
REQ-016 SD_MISO  input  1  serial data from card.

Function
REQ-017 FSM states: IDLE, SEND, WAIT, R1, EXT, TAIL, DONE; IDLE on reset.
REQ-018 IDLE + cmd_start: latch inputs, build frame {2'b01, cmd_index, cmd_arg, crc7, 1'b1}, clear resp_timeout, go SEND.
REQ-019 Bit period = 2*CLK_DIV clk cycles: SD_CK low first CLK_DIV cycles, high for remaining CLK_DIV; SD_MOSI changes only in first cycle of a bit period.
REQ-020 SD_MISO sampled in the clk cycle where SD_CK rises.
REQ-021 SEND: shift 48 frame bits MSB first, then WAIT.
REQ-022 WAIT: drive MOSI=1; first sampled 0 is R1 bit7, go R1; after 8*RESP_TIMEOUT bit periods with no 0, set resp_timeout, resp_r1=0xFF, go TAIL.
REQ-023 R1: capture remaining 7 bits; then EXT if resp_ext=1 else TAIL.
REQ-024 EXT: capture 32 bits into resp_data MSB first, then TAIL.
REQ-025 TAIL: 8 bit periods with MOSI=1 (Nec), then DONE.
REQ-026 DONE: cmd_done=1 for one cycle, cmd_busy drops next cycle, return IDLE.
REQ-027 cmd_start while cmd_busy=1 is ignored, no side effect.
REQ-028 cmd_start in the DONE cycle is ignored; earliest acceptance is the cycle after DONE.
REQ-029 resp_r1/resp_data hold value between transactions; resp_data unchanged when resp_ext=0.

Reset
REQ-030 rst_n=0 at any clk edge, including mid-frame: next cycle state=IDLE, SD_CK=0, SD_MOSI=1, cmd_busy=0, cmd_done=0, resp_r1=0xFF, resp_data=0, resp_timeout=0, all counters 0.
REQ-031 No partial transaction resumes after reset; no cmd_done is generated for the aborted command.

Configuration
REQ-032 Macro SD_CRC7_EN defined: crc7 computed in hardware (poly x^7+x^3+1, init 0) over the 40 bits {2'b01, cmd_index, cmd_arg}.
REQ-033 SD_CRC7_EN undefined: crc7 = 0x4A for CMD0, 0x43 for CMD8, 0x7F otherwise (frame byte 0x95/0x87/0xFF); no CRC logic.

Verification
REQ-034 CMD0 arg 0, card R1=0x01 -> MOSI bytes 40 00 00 00 00 95, resp_r1=0x01, cmd_done once, resp_timeout=0.
REQ-035 CMD8 arg 0x000001AA, resp_ext=1, card replies 01 00 00 01 AA -> MOSI 48 00 00 01 AA 87, resp_r1=0x01, resp_data=0x000001AA.
REQ-036 CMD0, SD_MISO held 1 -> resp_timeout=1, resp_r1=0xFF, cmd_done after 48+64+8 bit periods.
REQ-037 CMD55 arg 0 -> last frame byte 0x65 with SD_CRC7_EN, 0xFF without.
REQ-038 cmd_start pulsed during SEND -> ignored, frame unchanged, single cmd_done.
REQ-039 rst_n low during SEND bit 20 -> next cycle SD_CK=0, SD_MOSI=1, cmd_busy=0; new CMD0 then completes normally.
